// File: rtl/cmv_spi_master.sv
// rtl/cmv_spi_master.sv - 16-bit register-access SPI master for the CMV sensor config port.
// Optional macro CMV_SPI_READBACK_EN adds spi_miso capture into rd_data for read frames.
module cmv_spi_master #(
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2
) (
    input  logic       FSM_Clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       spi_en,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_LO,
        SCK_HI,
        HOLD
    } state_t;

    // Counters are loaded with N-1 so the state exits after exactly N cycles.
    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

    state_t      r_state;
    logic [15:0] r_shift;
    logic [3:0]  r_bit;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_spi_en;
    logic        r_spi_clk;
    logic        r_spi_mosi;

`ifdef CMV_SPI_READBACK_EN
    logic       r_rw;
    logic [7:0] r_rx;
    logic [7:0] r_rd_data;
`else
    logic w_unused_miso;
    assign w_unused_miso = spi_miso;
`endif

    always_ff @(posedge FSM_Clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= 16'h0000;
            r_bit      <= 4'd0;
            r_cnt      <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_spi_en   <= 1'b0;
            r_spi_clk  <= 1'b0;
            r_spi_mosi <= 1'b0;
`ifdef CMV_SPI_READBACK_EN
            r_rw       <= 1'b0;
            r_rx       <= 8'h00;
            r_rd_data  <= 8'h00;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift  <= {rw, addr, wr_data};
                        r_bit    <= 4'd15;
                        r_cnt    <= SETUP_LD;
                        r_busy   <= 1'b1;
                        r_spi_en <= 1'b1;
                        r_state  <= SETUP;
`ifdef CMV_SPI_READBACK_EN
                        r_rw     <= rw;
`endif
                    end
                end
                SETUP: begin
                    if (r_cnt == 4'd0) begin
                        r_spi_mosi <= r_shift[15];
                        r_state    <= SCK_LO;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                SCK_LO: begin
                    r_spi_clk <= 1'b1;
                    r_state   <= SCK_HI;
                end
                SCK_HI: begin
                    // The falling point: advance the frame and take the sensor's bit.
                    r_spi_clk <= 1'b0;
                    r_shift   <= {r_shift[14:0], 1'b0};
`ifdef CMV_SPI_READBACK_EN
                    r_rx      <= {r_rx[6:0], spi_miso};
`endif
                    if (r_bit == 4'd0) begin
                        r_spi_mosi <= 1'b0;
                        r_cnt      <= HOLD_LD;
                        r_state    <= HOLD;
                    end else begin
                        r_bit      <= r_bit - 4'd1;
                        r_spi_mosi <= r_shift[14];
                        r_state    <= SCK_LO;
                    end
                end
                HOLD: begin
                    if (r_cnt == 4'd0) begin
                        r_spi_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= IDLE;
`ifdef CMV_SPI_READBACK_EN
                        if (!r_rw) begin
                            r_rd_data <= r_rx;
                        end
`endif
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign spi_en   = r_spi_en;
    assign spi_clk  = r_spi_clk;
    assign spi_mosi = r_spi_mosi;
`ifdef CMV_SPI_READBACK_EN
    assign rd_data  = r_rd_data;
`else
    assign rd_data  = 8'h00;
`endif

endmodule

// File: tb/tb_cmv_spi_master.sv
// tb/tb_cmv_spi_master.sv - directed self-checking bench for cmv_spi_master.
module tb_cmv_spi_master;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = 7'h00;
    logic [7:0] wr_data = 8'h00;
    logic       spi_miso = 1'b0;

    logic       busy, done, spi_en, spi_clk, spi_mosi;
    logic [7:0] rd_data;
    logic       busy2, done2, spi_en2, spi_clk2, spi_mosi2;
    logic [7:0] rd_data2;

    int total = 0;
    int bad = 0;

`ifdef CMV_SPI_READBACK_EN
    localparam logic [7:0] EXP_RD = 8'h5A;
`else
    localparam logic [7:0] EXP_RD = 8'h00;
`endif

    cmv_spi_master #(.SETUP_CYC(2), .HOLD_CYC(2)) dut (
        .FSM_Clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr),
        .wr_data(wr_data), .busy(busy), .done(done), .rd_data(rd_data),
        .spi_en(spi_en), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    cmv_spi_master #(.SETUP_CYC(1), .HOLD_CYC(15)) dut2 (
        .FSM_Clk(clk), .reset(reset), .start(start2), .rw(rw), .addr(addr),
        .wr_data(wr_data), .busy(busy2), .done(done2), .rd_data(rd_data2),
        .spi_en(spi_en2), .spi_clk(spi_clk2), .spi_mosi(spi_mosi2), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame on dut from its accept edge (edge 0) through edge 50 and
    // acts as the sensor: returns the 16 bits seen at spi_clk rises and drives miso_b.
    task automatic do_frame(input logic i_rw, input logic [6:0] i_addr, input logic [7:0] i_data,
                            input logic [7:0] miso_b, input int pulse_at,
                            output logic [15:0] bits, output int first_rise, output int done_edge,
                            output int en_cyc, output int rises, output int dones,
                            output logic [7:0] rd_at_done, output int unstable);
        logic prev_clk, prev_mosi;
        bits = 16'h0; first_rise = -1; done_edge = -1; en_cyc = 0; rises = 0; dones = 0;
        rd_at_done = 8'hxx; unstable = 0; spi_miso = 1'b0;
        rw = i_rw; addr = i_addr; wr_data = i_data; start = 1'b1;
        tick();
        start = 1'b0;
        rw = ~i_rw; addr = ~i_addr; wr_data = ~i_data;
        if (spi_en) en_cyc++;
        prev_clk = spi_clk; prev_mosi = spi_mosi;
        for (int e = 1; e <= 50; e++) begin
            if (e == pulse_at) start = 1'b1;
            tick();
            start = 1'b0;
            if (spi_clk && !prev_clk) begin
                if (first_rise < 0) first_rise = e;
                bits = {bits[14:0], spi_mosi};
                if (spi_mosi !== prev_mosi) unstable++;
                spi_miso = (rises >= 8) ? miso_b[15 - rises] : 1'b0;
                rises++;
            end
            if (spi_en) en_cyc++;
            if (done) begin
                dones++;
                if (done_edge < 0) begin
                    done_edge = e;
                    rd_at_done = rd_data;
                end
            end
            prev_clk = spi_clk; prev_mosi = spi_mosi;
        end
        spi_miso = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        total++; if (spi_en !== 1'b0) begin bad++; $display("FAIL reset_spi_en got=%b exp=0", spi_en); end
        total++; if (spi_clk !== 1'b0) begin bad++; $display("FAIL reset_spi_clk got=%b exp=0", spi_clk); end
        total++; if (spi_mosi !== 1'b0) begin bad++; $display("FAIL reset_spi_mosi got=%b exp=0", spi_mosi); end
    endtask

    task automatic test_write();
        logic [15:0] bits; logic [7:0] rdv;
        int fr, de, en, ri, dn, un;
        do_frame(1'b1, 7'h2A, 8'hC3, 8'h00, 0, bits, fr, de, en, ri, dn, rdv, un);
        total++; if (bits !== 16'hAAC3) begin bad++; $display("FAIL write_bits got=%h exp=aac3", bits); end
        total++; if (ri != 16) begin bad++; $display("FAIL write_rises got=%0d exp=16", ri); end
        total++; if (fr != 3) begin bad++; $display("FAIL write_first_rise got=%0d exp=3", fr); end
        total++; if (de != 36) begin bad++; $display("FAIL write_done_edge got=%0d exp=36", de); end
        total++; if (en != 36) begin bad++; $display("FAIL write_en_cycles got=%0d exp=36", en); end
        total++; if (dn != 1) begin bad++; $display("FAIL write_done_count got=%0d exp=1", dn); end
        total++; if (un != 0) begin bad++; $display("FAIL write_mosi_setup got=%0d exp=0", un); end
        total++; if (rdv !== 8'h00) begin bad++; $display("FAIL write_rd_data got=%h exp=00", rdv); end
    endtask

    task automatic test_read();
        logic [15:0] bits; logic [7:0] rdv;
        int fr, de, en, ri, dn, un;
        do_frame(1'b0, 7'h05, 8'h00, 8'h5A, 0, bits, fr, de, en, ri, dn, rdv, un);
        total++; if (bits !== 16'h0500) begin bad++; $display("FAIL read_bits got=%h exp=0500", bits); end
        total++; if (de != 36) begin bad++; $display("FAIL read_done_edge got=%0d exp=36", de); end
        total++; if (rdv !== EXP_RD) begin bad++; $display("FAIL read_rd_data got=%h exp=%h", rdv, EXP_RD); end
    endtask

    task automatic test_ignore_start();
        logic [15:0] bits; logic [7:0] rdv;
        int fr, de, en, ri, dn, un;
        do_frame(1'b1, 7'h2A, 8'hC3, 8'hFF, 10, bits, fr, de, en, ri, dn, rdv, un);
        total++; if (bits !== 16'hAAC3) begin bad++; $display("FAIL ignore_bits got=%h exp=aac3", bits); end
        total++; if (dn != 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", dn); end
        total++; if (de != 36) begin bad++; $display("FAIL ignore_done_edge got=%0d exp=36", de); end
        total++; if (rdv !== EXP_RD) begin bad++; $display("FAIL ignore_rd_kept got=%h exp=%h", rdv, EXP_RD); end
    endtask

    task automatic test_back_to_back();
        int nd = 0; int d1 = -1; int d2 = -1;
        int run = 0; int min_gap = 999; int max_gap = 0; int gaps = 0;
        logic was_high = 1'b0;
        logic finished = 1'b0;
        rw = 1'b1; addr = 7'h2A; wr_data = 8'hC3; start = 1'b1;
        for (int e = 0; e <= 115; e++) begin
            tick();
            if (done) begin
                nd++;
                if (d1 < 0) d1 = e; else if (d2 < 0) d2 = e;
            end
            if (spi_en) begin
                if (run > 0) begin
                    gaps++;
                    if (run < min_gap) min_gap = run;
                    if (run > max_gap) max_gap = run;
                end
                run = 0; was_high = 1'b1;
            end else if (was_high) begin
                run++;
            end
        end
        start = 1'b0;
        for (int e = 0; e < 60 && !finished; e++) begin
            tick();
            if (!busy) finished = 1'b1;
        end
        total++; if (nd != 3) begin bad++; $display("FAIL b2b_done_count got=%0d exp=3", nd); end
        total++; if (d1 != 36) begin bad++; $display("FAIL b2b_first_done got=%0d exp=36", d1); end
        total++; if (d2 != 73) begin bad++; $display("FAIL b2b_second_done got=%0d exp=73", d2); end
        total++; if (gaps != 3 || min_gap != 1 || max_gap != 1) begin
            bad++; $display("FAIL b2b_en_gap got=n%0d/min%0d/max%0d exp=n3/min1/max1", gaps, min_gap, max_gap);
        end
        total++; if (!finished) begin bad++; $display("FAIL b2b_drain got=busy exp=idle"); end
        total++; if (rd_data !== EXP_RD) begin bad++; $display("FAIL b2b_rd_kept got=%h exp=%h", rd_data, EXP_RD); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] bits; logic [7:0] rdv;
        int fr, de, en, ri, dn, un;
        int spurious = 0;
        rw = 1'b0; addr = 7'h33; wr_data = 8'h55; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e < 20; e++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if ({spi_en, spi_clk, busy, done, spi_mosi} !== 5'b0) begin
            bad++; $display("FAIL midreset_outputs got=%b exp=00000", {spi_en, spi_clk, busy, done, spi_mosi});
        end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL midreset_rd_data got=%h exp=00", rd_data); end
        for (int e = 0; e < 40; e++) begin
            tick();
            if (done || spi_en) spurious++;
        end
        total++; if (spurious != 0) begin bad++; $display("FAIL midreset_quiet got=%0d exp=0", spurious); end
        do_frame(1'b1, 7'h11, 8'h3C, 8'h00, 0, bits, fr, de, en, ri, dn, rdv, un);
        total++; if (bits !== 16'h913C) begin bad++; $display("FAIL midreset_new_bits got=%h exp=913c", bits); end
        total++; if (de != 36) begin bad++; $display("FAIL midreset_new_done got=%0d exp=36", de); end
    endtask

    task automatic test_setup1_hold15();
        int fr = -1; int de = -1; int ri = 0;
        logic prev_clk;
        rw = 1'b1; addr = 7'h2A; wr_data = 8'hC3; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        total++; if (busy2 !== 1'b1 || spi_en2 !== 1'b1) begin
            bad++; $display("FAIL cfg_accept got=%b%b exp=11", busy2, spi_en2);
        end
        prev_clk = spi_clk2;
        for (int e = 1; e <= 70; e++) begin
            tick();
            if (spi_clk2 && !prev_clk) begin
                ri++;
                if (fr < 0) fr = e;
            end
            if (done2 && de < 0) de = e;
            prev_clk = spi_clk2;
        end
        total++; if (fr != 2) begin bad++; $display("FAIL cfg_first_rise got=%0d exp=2", fr); end
        total++; if (de != 48) begin bad++; $display("FAIL cfg_done_edge got=%0d exp=48", de); end
        total++; if (ri != 16) begin bad++; $display("FAIL cfg_rises got=%0d exp=16", ri); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_setup1_hold15();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
